// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC/nPC pair with delayed branches, IF/ID capture, stall/flush/redirect.
// Optional FETCH_NULLIFY_EN: nullify squashes the delay-slot instruction of a taken branch.
module fetch_unit #(
    parameter int             AW       = 8,
    parameter int             IW       = 32,
    parameter logic [AW-1:0]  RESET_PC = {AW{1'b0}}
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          stall,
    input  logic          flush,
    input  logic          br_taken,
    input  logic [AW-1:0] br_target,
    input  logic          nullify,
    output logic [AW-1:0] A,
    input  logic [IW-1:0] I,
    output logic [IW-1:0] instr,
    output logic [AW-1:0] instr_pc,
    output logic [AW-1:0] instr_npc,
    output logic          instr_valid,
    output logic          redirect_pending
);

    localparam logic [AW-1:0] STEP = AW'(3'd4);

    logic [AW-1:0] pc_r;
    logic [AW-1:0] npc_r;
    logic [AW-1:0] pend_tgt_r;
    logic [AW-1:0] br_tgt_aligned_s;
    logic [AW-1:0] npc_seq_s;
    logic [AW-1:0] tgt_s;
    logic          redirect_s;
    logic          kill_s;

    assign A = pc_r;

    // Next-address selection: a fresh branch beats a stored pending one.
    always_comb begin
        br_tgt_aligned_s = {br_target[AW-1:2], 2'b00};
        npc_seq_s        = npc_r + STEP;
        redirect_s       = br_taken | redirect_pending;
        if (br_taken) begin
            tgt_s = br_tgt_aligned_s;
        end else begin
            tgt_s = pend_tgt_r;
        end
    end

`ifdef FETCH_NULLIFY_EN
    logic pend_nul_r;
    logic slot_nul_r;
    logic slot_nul_next_s;

    // The nullify flag travels with whichever redirect is applied.
    always_comb begin
        if (redirect_s) begin
            if (br_taken) begin
                slot_nul_next_s = nullify;
            end else begin
                slot_nul_next_s = pend_nul_r;
            end
        end else begin
            slot_nul_next_s = 1'b0;
        end
    end

    // Nullify state: stored with a stalled branch, armed for the delay-slot load.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_nul_r <= 1'b0;
            slot_nul_r <= 1'b0;
        end else if (stall) begin
            if (br_taken) begin
                pend_nul_r <= nullify;
            end
        end else begin
            pend_nul_r <= 1'b0;
            slot_nul_r <= slot_nul_next_s;
        end
    end

    assign kill_s = slot_nul_r;
`else
    logic unused_nullify_s;
    assign unused_nullify_s = nullify;
    assign kill_s           = 1'b0;
`endif

    // PC/nPC, pending redirect and IF/ID register update.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_r             <= RESET_PC;
            npc_r            <= RESET_PC + STEP;
            pend_tgt_r       <= {AW{1'b0}};
            redirect_pending <= 1'b0;
            instr            <= {IW{1'b0}};
            instr_pc         <= {AW{1'b0}};
            instr_npc        <= {AW{1'b0}};
            instr_valid      <= 1'b0;
        end else if (stall) begin
            if (br_taken) begin
                pend_tgt_r       <= br_tgt_aligned_s;
                redirect_pending <= 1'b1;
            end
            if (flush) begin
                instr_valid <= 1'b0;
            end
        end else begin
            pc_r             <= npc_r;
            npc_r            <= redirect_s ? tgt_s : npc_seq_s;
            redirect_pending <= 1'b0;
            instr            <= I;
            instr_pc         <= pc_r;
            instr_npc        <= npc_r;
            instr_valid      <= ~flush & ~kill_s;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed, table-driven bench for fetch_unit against a 256-byte word memory model.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset, stall, flush, br_taken, nullify;
    logic [7:0]  br_target;
    logic [7:0]  a_s;
    logic [31:0] i_s;
    logic [31:0] instr;
    logic [7:0]  instr_pc, instr_npc;
    logic        instr_valid, redirect_pending;

    int tests = 0;
    int fails = 0;

`ifdef FETCH_NULLIFY_EN
    localparam bit NUL_EN = 1'b1;
`else
    localparam bit NUL_EN = 1'b0;
`endif

    typedef struct {
        bit       rst, stl, fls, bt, nul;
        bit [7:0] tgt;
        bit [7:0] exp_a;
        bit       exp_v;
        bit [7:0] exp_ipc, exp_inpc;
        bit       exp_p;
    } vec_t;

    vec_t vecs[$];

    fetch_unit #(.AW(8), .IW(32), .RESET_PC(8'd0)) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .br_taken(br_taken), .br_target(br_target), .nullify(nullify),
        .A(a_s), .I(i_s), .instr(instr), .instr_pc(instr_pc),
        .instr_npc(instr_npc), .instr_valid(instr_valid),
        .redirect_pending(redirect_pending)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [7:0] addr);
        return {8'hC0, addr, ~addr, 8'h5A};
    endfunction

    assign i_s = word(a_s);

    task automatic add(input bit rst, input bit stl, input bit fls, input bit bt,
                       input bit [7:0] tgt, input bit nul, input bit [7:0] ea,
                       input bit ev, input bit [7:0] eipc, input bit [7:0] einpc,
                       input bit ep);
        vec_t v;
        v.rst = rst; v.stl = stl; v.fls = fls; v.bt = bt; v.tgt = tgt; v.nul = nul;
        v.exp_a = ea; v.exp_v = ev; v.exp_ipc = eipc; v.exp_inpc = einpc; v.exp_p = ep;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        //   rst stl fls bt tgt    nul  A      v  ipc    inpc   pend
        add(1, 0, 0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 8'h00, 0); // 0 reset
        add(0, 0, 0, 0, 8'h00, 0, 8'h04, 1, 8'h00, 8'h04, 0); // 1 W0 valid
        add(0, 0, 0, 0, 8'h00, 0, 8'h08, 1, 8'h04, 8'h08, 0);
        add(0, 0, 0, 1, 8'h41, 0, 8'h0C, 1, 8'h08, 8'h0C, 0); // 3 branch at PC=8
        add(0, 0, 0, 0, 8'h00, 0, 8'h40, 1, 8'h0C, 8'h40, 0);
        add(0, 0, 0, 0, 8'h00, 0, 8'h44, 1, 8'h40, 8'h44, 0);
        add(0, 0, 0, 1, 8'h10, 0, 8'h48, 1, 8'h44, 8'h48, 0);
        add(0, 0, 0, 0, 8'h00, 0, 8'h10, 1, 8'h48, 8'h10, 0);
        add(0, 1, 0, 0, 8'h00, 0, 8'h10, 1, 8'h48, 8'h10, 0); // 8 stall x3
        add(0, 1, 0, 1, 8'h80, 0, 8'h10, 1, 8'h48, 8'h10, 1);
        add(0, 1, 0, 0, 8'h00, 0, 8'h10, 1, 8'h48, 8'h10, 1);
        add(0, 0, 0, 0, 8'h00, 0, 8'h14, 1, 8'h10, 8'h14, 0); // 11 release
        add(0, 0, 0, 0, 8'h00, 0, 8'h80, 1, 8'h14, 8'h80, 0);
        add(0, 0, 0, 1, 8'h18, 0, 8'h84, 1, 8'h80, 8'h84, 0);
        add(0, 0, 0, 0, 8'h00, 0, 8'h18, 1, 8'h84, 8'h18, 0);
        add(0, 0, 1, 0, 8'h00, 0, 8'h1C, 0, 8'h18, 8'h1C, 0); // 15 flush
        add(0, 0, 0, 0, 8'h00, 0, 8'h20, 1, 8'h1C, 8'h20, 0);
        add(0, 0, 0, 1, 8'h60, 1, 8'h24, 1, 8'h20, 8'h24, 0); // 17 br+nullify at 32
        add(0, 0, 0, 0, 8'h00, 0, 8'h60, !NUL_EN, 8'h24, 8'h60, 0);
        add(0, 0, 0, 0, 8'h00, 0, 8'h64, 1, 8'h60, 8'h64, 0);
        add(0, 0, 0, 1, 8'hF8, 0, 8'h68, 1, 8'h64, 8'h68, 0);
        add(0, 0, 0, 0, 8'h00, 0, 8'hF8, 1, 8'h68, 8'hF8, 0);
        add(0, 0, 0, 0, 8'h00, 0, 8'hFC, 1, 8'hF8, 8'hFC, 0);
        add(0, 0, 0, 0, 8'h00, 0, 8'h00, 1, 8'hFC, 8'h00, 0); // 23 wrap
        add(0, 1, 1, 0, 8'h00, 0, 8'h00, 0, 8'hFC, 8'h00, 0); // 24 stall+flush
        add(0, 0, 0, 0, 8'h00, 0, 8'h04, 1, 8'h00, 8'h04, 0);
        add(0, 1, 0, 1, 8'h90, 0, 8'h04, 1, 8'h00, 8'h04, 1); // 26 pending
        add(0, 1, 0, 1, 8'hA3, 0, 8'h04, 1, 8'h00, 8'h04, 1); // 27 overwrite
        add(0, 0, 0, 0, 8'h00, 0, 8'h08, 1, 8'h04, 8'h08, 0);
        add(0, 0, 0, 0, 8'h00, 0, 8'hA0, 1, 8'h08, 8'hA0, 0);
        add(0, 1, 0, 1, 8'h30, 0, 8'hA0, 1, 8'h08, 8'hA0, 1);
        add(1, 1, 0, 1, 8'h44, 0, 8'h00, 0, 8'h00, 8'h00, 0); // 31 reset wins
        add(0, 0, 0, 0, 8'h00, 0, 8'h04, 1, 8'h00, 8'h04, 0);
        add(0, 0, 0, 0, 8'h00, 0, 8'h08, 1, 8'h04, 8'h08, 0);
        add(0, 1, 0, 1, 8'h50, 0, 8'h08, 1, 8'h04, 8'h08, 1);
        add(0, 0, 0, 1, 8'h70, 0, 8'h0C, 1, 8'h08, 8'h0C, 0); // 35 fresh beats pending
        add(0, 0, 0, 0, 8'h00, 0, 8'h70, 1, 8'h0C, 8'h70, 0);

        reset = 1'b1; stall = 1'b0; flush = 1'b0; br_taken = 1'b0;
        br_target = 8'h00; nullify = 1'b0;
        @(negedge clk);
        check("A_during_reset", {24'h0, a_s}, 32'h0);

        for (int k = 0; k < vecs.size(); k++) begin
            reset     = vecs[k].rst;
            stall     = vecs[k].stl;
            flush     = vecs[k].fls;
            br_taken  = vecs[k].bt;
            br_target = vecs[k].tgt;
            nullify   = vecs[k].nul;
            @(posedge clk);
            #1;
            check($sformatf("v%0d_A", k), {24'h0, a_s}, {24'h0, vecs[k].exp_a});
            check($sformatf("v%0d_valid", k), {31'h0, instr_valid}, {31'h0, vecs[k].exp_v});
            check($sformatf("v%0d_instr_pc", k), {24'h0, instr_pc}, {24'h0, vecs[k].exp_ipc});
            check($sformatf("v%0d_instr_npc", k), {24'h0, instr_npc}, {24'h0, vecs[k].exp_inpc});
            check($sformatf("v%0d_pending", k), {31'h0, redirect_pending}, {31'h0, vecs[k].exp_p});
            if (vecs[k].rst) begin
                check($sformatf("v%0d_instr_rst", k), instr, 32'h0);
            end else if (vecs[k].exp_v || vecs[k].fls) begin
                check($sformatf("v%0d_instr", k), instr, word(vecs[k].exp_ipc));
            end
        end

        // Hand sequence: a stalled branch with nullify carried to the applied redirect.
        reset = 1'b1; stall = 1'b0; flush = 1'b0; br_taken = 1'b0; nullify = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0; stall = 1'b1; br_taken = 1'b1; br_target = 8'hC2; nullify = 1'b1;
        @(posedge clk); #1;
        check("hs_pending_set", {31'h0, redirect_pending}, 32'h1);
        stall = 1'b0; br_taken = 1'b0; nullify = 1'b0;
        @(posedge clk); #1;
        check("hs_release_A", {24'h0, a_s}, 32'h04);
        check("hs_release_valid", {31'h0, instr_valid}, 32'h1);
        @(posedge clk); #1;
        check("hs_target_A", {24'h0, a_s}, 32'hC0);
        check("hs_slot_valid", {31'h0, instr_valid}, {31'h0, !NUL_EN});
        check("hs_slot_pc", {24'h0, instr_pc}, 32'h04);
        @(posedge clk); #1;
        check("hs_after_slot_valid", {31'h0, instr_valid}, 32'h1);
        check("hs_after_slot_A", {24'h0, a_s}, 32'hC4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
